// File: rtl/sdram_32b_bridge.sv
// sdram_32b_bridge: splits 32-bit CPU word accesses into 16-bit toggle req/ack SDRAM controller transactions
module sdram_32b_bridge #(
  parameter int w_addr = 23,
  parameter int timeout_cycles = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [w_addr-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [w_addr:0]   ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              ram_wrl,
  output logic              ram_wrh,
  output logic              ram_req,
  input  logic              ram_ack
);
  localparam int CW = $clog2(timeout_cycles);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
  state_t            st_q;
  logic              we_q;
  logic [1:0]        be_hi_q;
  logic [w_addr-1:0] addr_q;
  logic [15:0]       wdata_hi_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rdata_q;
  logic [w_addr:0]   ram_addr_q;
  logic [15:0]       ram_wdata_q;
  logic              ram_wrl_q, ram_wrh_q, ram_req_q, done_q, err_q;
  assign cpu_ready = st_q == IDLE;
  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wrl   = ram_wrl_q;
  assign ram_wrh   = ram_wrh_q;
  assign ram_req   = ram_req_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      ram_req_q   <= ram_ack;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wrl_q   <= 1'b0;
      ram_wrh_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_hi_q     <= '0;
      addr_q      <= '0;
      wdata_hi_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (st_q)
        IDLE: if (cpu_req) begin
          we_q       <= cpu_we;
          be_hi_q    <= cpu_be[3:2];
          addr_q     <= cpu_addr;
          wdata_hi_q <= cpu_wdata[31:16];
          cnt_q      <= '0;
          if (cpu_we && cpu_be == 4'h0) begin
            st_q   <= RESP;
            done_q <= 1'b1;
          end else if (cpu_we && cpu_be[1:0] == 2'b00) begin
            ram_addr_q  <= {cpu_addr, 1'b1};
            ram_wdata_q <= cpu_wdata[31:16];
            ram_wrl_q   <= cpu_be[2];
            ram_wrh_q   <= cpu_be[3];
            ram_req_q   <= ~ram_req_q;
            st_q        <= HI;
          end else begin
            ram_addr_q  <= {cpu_addr, 1'b0};
            ram_wdata_q <= cpu_wdata[15:0];
            ram_wrl_q   <= cpu_we & cpu_be[0];
            ram_wrh_q   <= cpu_we & cpu_be[1];
            ram_req_q   <= ~ram_req_q;
            st_q        <= LO;
          end
        end
        LO, HI: if (ram_ack == ram_req_q) begin
          if (st_q == LO) begin
            if (!we_q) rdata_q[15:0] <= ram_rdata;
            if (!we_q || be_hi_q != 2'b00) begin
              ram_addr_q  <= {addr_q, 1'b1};
              ram_wdata_q <= wdata_hi_q;
              ram_wrl_q   <= we_q & be_hi_q[0];
              ram_wrh_q   <= we_q & be_hi_q[1];
              ram_req_q   <= ~ram_req_q;
              cnt_q       <= '0;
              st_q        <= HI;
            end else begin
              st_q   <= RESP;
              done_q <= 1'b1;
            end
          end else begin
            if (!we_q) rdata_q[31:16] <= ram_rdata;
            st_q   <= RESP;
            done_q <= 1'b1;
          end
        end else if (cnt_q == CW'(timeout_cycles - 1)) begin
          // abandon: realign req to ack so the next transaction starts clean
          ram_req_q <= ram_ack;
          st_q      <= RESP;
          done_q    <= 1'b1;
          err_q     <= 1'b1;
          if (!we_q) begin
            rdata_q[31:16] <= '0;
            if (st_q == LO) rdata_q[15:0] <= '0;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_32b_bridge.sv
// tb_sdram_32b_bridge: scoreboard bench with a toggle req/ack controller model
module tb_sdram_32b_bridge;
  typedef struct packed {logic [23:0] a; logic [15:0] d; logic l; logic h;} txn_t;
  typedef struct packed {logic [31:0] rd; logic e; int lat;} resp_t;
  logic clk = 0, rst_n = 0, cpu_req = 0, cpu_we = 0;
  logic [3:0] cpu_be = 0;
  logic [22:0] cpu_addr = 0;
  logic [31:0] cpu_wdata = 0;
  logic cpu_ready, cpu_done, cpu_err, ram_wrl, ram_wrh, ram_req;
  logic [31:0] cpu_rdata;
  logic [23:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 0;
  logic ram_ack = 1;
  logic ack_en = 1, prev_req = 0;
  int total = 0, bad = 0, cyc = 0, tog_cyc = 0, dly = 0;
  txn_t exp_t[$];
  resp_t exp_r[$];
  logic [15:0] rd_q[$];
  txn_t t;
  resp_t r;
  sdram_32b_bridge #(.w_addr(23), .timeout_cycles(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_wrl(ram_wrl), .ram_wrh(ram_wrh), .ram_req(ram_req), .ram_ack(ram_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected", n);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // controller model: acks three cycles after each toggle while enabled
  always @(posedge clk)
    if (ack_en && ram_req != ram_ack) begin
      if (dly == 2) begin
        ram_ack   <= ram_req;
        ram_rdata <= rd_q.size() > 0 ? rd_q.pop_front() : 16'h0;
        dly       <= 0;
      end else dly <= dly + 1;
    end else dly <= 0;
  always @(negedge clk) begin
    if (rst_n && ram_req != prev_req && ram_req != ram_ack) begin
      tog_cyc = cyc;
      if (exp_t.size() == 0) fail("spur_txn");
      else begin
        t = exp_t.pop_front();
        chk("txn", {ram_addr, ram_wdata, ram_wrl, ram_wrh}, t);
      end
    end
    prev_req = ram_req;
    if (cpu_done) begin
      if (exp_r.size() == 0) fail("spur_done");
      else begin
        r = exp_r.pop_front();
        chk("rdata", cpu_rdata, r.rd);
        chk("err", cpu_err, r.e);
        if (r.lat >= 0) chk("lat", cyc - tog_cyc, r.lat);
      end
    end else if (cpu_err) fail("err_no_done");
  end
  task automatic op(input logic we, input logic [3:0] be, input logic [22:0] a, input logic [31:0] wd);
    int n = 0;
    while (!cpu_ready && n < 100) begin @(posedge clk); #1; n++; end
    cpu_req = 1; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!cpu_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) fail("idle_timeout");
  endtask
  task automatic pt(input logic [23:0] a, input logic [15:0] d, input logic l, input logic h);
    exp_t.push_back({a, d, l, h});
  endtask
  task automatic pr(input logic [31:0] rd, input logic e, input int lat);
    exp_r.push_back({rd, e, lat});
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", ram_req, 1);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    rst_n = 1;
    pt(24'h20, 16'hBEEF, 1, 1); pt(24'h21, 16'hDEAD, 1, 1); pr(0, 0, -1);
    op(1, 4'hF, 23'h10, 32'hDEADBEEF); wait_idle();
    rd_q.push_back(16'h1234); rd_q.push_back(16'h5678);
    pt(24'h8, 0, 0, 0); pt(24'h9, 0, 0, 0); pr(32'h56781234, 0, -1);
    op(0, 4'h0, 23'h4, 0); wait_idle();
    pt(24'h201, 16'hCAFE, 0, 1); pr(32'h56781234, 0, -1);
    op(1, 4'b1000, 23'h100, 32'hCAFEF00D); wait_idle();
    pt(24'hFFFFFE, 16'h3344, 1, 1); pr(32'h56781234, 0, -1);
    op(1, 4'b0011, 23'h7FFFFF, 32'h11223344); wait_idle();
    pt(24'h80, 16'hC3D4, 0, 1); pt(24'h81, 16'hA1B2, 1, 0); pr(32'h56781234, 0, -1);
    op(1, 4'b0110, 23'h40, 32'hA1B2C3D4); wait_idle();
    pr(32'h56781234, 0, -1);
    op(1, 4'b0000, 23'h55, 32'h12345678);
    chk("be0_done", cpu_done, 1);
    chk("be0_nosend", ram_req, ram_ack);
    wait_idle();
    ack_en = 0;
    pt(24'h6, 0, 0, 0); pr(0, 1, 16);
    op(0, 4'h0, 23'h3, 0); wait_idle();
    chk("to_sync", ram_req, ram_ack);
    ack_en = 1;
    rd_q.push_back(16'hAAAA); rd_q.push_back(16'h5555);
    pt(24'h4, 0, 0, 0); pt(24'h5, 0, 0, 0); pr(32'h5555AAAA, 0, -1);
    op(0, 4'h0, 23'h2, 0); wait_idle();
    rd_q.push_back(16'h1111);
    pt(24'h12, 0, 0, 0); pt(24'h13, 0, 0, 0);
    op(0, 4'h0, 23'h9, 0);
    n = 0;
    while (!(ram_addr == 24'h13 && ram_req != ram_ack) && n < 50) begin @(posedge clk); #1; n++; end
    ack_en = 0;
    if (n == 50) fail("reach_hi");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_ready", cpu_ready, 1);
    chk("mid_sync", ram_req, ram_ack);
    chk("mid_done", cpu_done, 0);
    chk("mid_rdata", cpu_rdata, 0);
    rst_n = 1;
    ack_en = 1;
    rd_q.push_back(16'hBEEF); rd_q.push_back(16'h0BAD);
    pt(24'hE, 0, 0, 0); pt(24'hF, 0, 0, 0); pr(32'h0BADBEEF, 0, -1);
    op(0, 4'h0, 23'h7, 0); wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("txn_left", exp_t.size(), 0);
    chk("resp_left", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
